// File: rtl/control_ajuste_reloj_if.sv
// Signal bundle between the clock controller and the buttons / hh:mm:ss counter chain.
interface control_ajuste_reloj_if;
    logic       pulsador_modo;
    logic       pulsador_inc;
    logic       fin_seg;
    logic       fin_min;
    logic       en_seg;
    logic       en_min;
    logic       en_hora;
    logic [1:0] modo;
    logic       parpadeo;

    modport master (
        input  pulsador_modo, pulsador_inc, fin_seg, fin_min,
        output en_seg, en_min, en_hora, modo, parpadeo
    );

    modport slave (
        output pulsador_modo, pulsador_inc, fin_seg, fin_min,
        input  en_seg, en_min, en_hora, modo, parpadeo
    );
endinterface

// File: rtl/control_ajuste_reloj.sv
// Clock-setting controller: 1 s prescaler, button debounce, RUN/SET_HORA/SET_MIN
// mode FSM, counter enables and blink generation for the hh:mm:ss chain.
module control_ajuste_reloj #(
    parameter int DIV_SEG      = 50_000_000,
    parameter int DEB_CICLOS   = 500_000,
    parameter int DIV_PARPADEO = 12_500_000
) (
    input  logic                   clock,
    input  logic                   reset,
    control_ajuste_reloj_if.master bus
);
    function automatic int clogb2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((v >> i) != 32'sd0) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    localparam int SEG_W = clogb2(DIV_SEG - 1);
    localparam int DEB_W = clogb2(DEB_CICLOS);
    localparam int PAR_W = clogb2(DIV_PARPADEO - 1);

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(DIV_SEG - 1);
    localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);
    localparam logic [SEG_W-1:0] SEG_ZERO = SEG_W'(0);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CICLOS - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_ZERO = DEB_W'(0);
    localparam logic [PAR_W-1:0] PAR_LAST = PAR_W'(DIV_PARPADEO - 1);
    localparam logic [PAR_W-1:0] PAR_ONE  = PAR_W'(1);
    localparam logic [PAR_W-1:0] PAR_ZERO = PAR_W'(0);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HORA = 2'b01,
        SET_MIN  = 2'b10
    } modo_e;

    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0]            raw_s;
    logic [1:0]            sync1_q, sync2_q, deb_q, deb_d, pulse_s;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic                  p_modo_s, p_inc_s;

    modo_e                 modo_q, modo_d;
    logic [SEG_W-1:0]      pre_q, pre_d;
    logic                  tick_s;
    logic [PAR_W-1:0]      par_cnt_q, par_cnt_d;
    logic                  parpadeo_q, parpadeo_d;
    logic                  en_seg_q, en_seg_d;
    logic                  en_min_q, en_min_d;
    logic                  en_hora_q, en_hora_d;

    assign raw_s    = {bus.pulsador_inc, bus.pulsador_modo};
    assign p_modo_s = pulse_s[0];
    assign p_inc_s  = pulse_s[1];

    // Debounce: accept a new level after DEB_CICLOS consecutive differing cycles; pulse on rising acceptance.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        pulse_s   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = DEB_ZERO;
                    pulse_s[i]   = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
                end
            end else begin
                deb_cnt_d[i] = DEB_ZERO;
            end
        end
    end

    // Mode FSM next state.
    always_comb begin
        modo_d = modo_q;
        if (p_modo_s) begin
            case (modo_q)
                RUN:      modo_d = SET_HORA;
                SET_HORA: modo_d = SET_MIN;
                SET_MIN:  modo_d = RUN;
                default:  modo_d = RUN;
            endcase
        end else begin
            modo_d = modo_q;
        end
    end

    // Prescaler, enables and blink; a mode change beats a simultaneous increment.
    always_comb begin
        tick_s     = (modo_q == RUN) && (pre_q == SEG_LAST);
        pre_d      = SEG_ZERO;
        en_seg_d   = 1'b0;
        en_min_d   = 1'b0;
        en_hora_d  = 1'b0;
        par_cnt_d  = PAR_ZERO;
        parpadeo_d = 1'b0;

        if ((modo_q == RUN) && (modo_d == RUN)) begin
            pre_d = tick_s ? SEG_ZERO : (pre_q + SEG_ONE);
        end else begin
            pre_d = SEG_ZERO;
        end

        case (modo_q)
            RUN: begin
                en_seg_d  = tick_s;
                en_min_d  = tick_s & bus.fin_seg;
                en_hora_d = tick_s & bus.fin_seg & bus.fin_min;
            end
            SET_HORA: en_hora_d = p_inc_s & ~p_modo_s;
            SET_MIN:  en_min_d  = p_inc_s & ~p_modo_s;
            default: begin
                en_seg_d  = 1'b0;
                en_min_d  = 1'b0;
                en_hora_d = 1'b0;
            end
        endcase

        if (modo_d != modo_q) begin
            par_cnt_d  = PAR_ZERO;
            parpadeo_d = (modo_d != RUN);
        end else if (modo_q != RUN) begin
            if (par_cnt_q == PAR_LAST) begin
                par_cnt_d  = PAR_ZERO;
                parpadeo_d = ~parpadeo_q;
            end else begin
                par_cnt_d  = par_cnt_q + PAR_ONE;
                parpadeo_d = parpadeo_q;
            end
        end else begin
            par_cnt_d  = PAR_ZERO;
            parpadeo_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            deb_q      <= 2'b00;
            deb_cnt_q  <= {2{DEB_ZERO}};
            modo_q     <= RUN;
            pre_q      <= SEG_ZERO;
            par_cnt_q  <= PAR_ZERO;
            parpadeo_q <= 1'b0;
            en_seg_q   <= 1'b0;
            en_min_q   <= 1'b0;
            en_hora_q  <= 1'b0;
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            modo_q     <= modo_d;
            pre_q      <= pre_d;
            par_cnt_q  <= par_cnt_d;
            parpadeo_q <= parpadeo_d;
            en_seg_q   <= en_seg_d;
            en_min_q   <= en_min_d;
            en_hora_q  <= en_hora_d;
        end
    end

    assign bus.en_seg   = en_seg_q;
    assign bus.en_min   = en_min_q;
    assign bus.en_hora  = en_hora_q;
    assign bus.modo     = modo_q;
    assign bus.parpadeo = parpadeo_q;
endmodule

// File: tb/tb_control_ajuste_reloj.sv
// Directed bench for control_ajuste_reloj with a timestamp-based reference model.
module tb_control_ajuste_reloj;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   n_seg, n_min, n_hora;

    control_ajuste_reloj_if bus();

    control_ajuste_reloj #(
        .DIV_SEG(10), .DEB_CICLOS(4), .DIV_PARPADEO(3)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: edge index since reset release, button history, mode entry times.
    bit       exp_en_seg = 1'b0, exp_en_min = 1'b0, exp_en_hora = 1'b0, exp_par = 1'b0;
    int       exp_modo = 0;
    int       m = 0, mode = 0, t_run = 0, t_enter = 0;
    bit       deb_m = 1'b0, deb_i = 1'b0;
    bit       hist_m [0:4095];
    bit       hist_i [0:4095];

    always @(posedge clk or negedge rst_n) begin : model
        int mn, mode_new, te;
        bit v, ok, pm, pi, seg, rv;
        if (!rst_n) begin
            m <= 0; mode <= 0; t_run <= 0; t_enter <= 0;
            deb_m <= 1'b0; deb_i <= 1'b0;
            exp_en_seg <= 1'b0; exp_en_min <= 1'b0; exp_en_hora <= 1'b0;
            exp_par <= 1'b0; exp_modo <= 0;
        end else begin
            mn = m + 1;
            pm = 1'b0;
            pi = 1'b0;
            v  = !deb_m;
            ok = 1'b1;
            for (int k = mn - 5; k <= mn - 2; k++) begin
                rv = (k >= 1) ? hist_m[k] : 1'b0;
                if (rv != v) ok = 1'b0;
            end
            if (ok) begin
                deb_m <= v;
                pm = v;
            end
            v  = !deb_i;
            ok = 1'b1;
            for (int k = mn - 5; k <= mn - 2; k++) begin
                rv = (k >= 1) ? hist_i[k] : 1'b0;
                if (rv != v) ok = 1'b0;
            end
            if (ok) begin
                deb_i <= v;
                pi = v;
            end
            mode_new = pm ? (mode + 1) % 3 : mode;
            seg = (mode == 0) && (mn > t_run) && ((mn - t_run) % 10 == 0);
            exp_en_seg  <= seg;
            exp_en_min  <= (mode == 0) ? (seg && bus.fin_seg) : ((mode == 2) && pi && !pm);
            exp_en_hora <= (mode == 0) ? (seg && bus.fin_seg && bus.fin_min) : ((mode == 1) && pi && !pm);
            exp_modo    <= mode_new;
            te = pm ? mn : t_enter;
            exp_par     <= (mode_new == 0) ? 1'b0 : ((((mn - te) / 3) % 2) == 0);
            if (pm) t_enter <= mn;
            if (pm && mode_new == 0) t_run <= mn;
            mode <= mode_new;
            if (mn < 4096) begin
                hist_m[mn] <= bus.pulsador_modo;
                hist_i[mn] <= bus.pulsador_inc;
            end
            m <= mn;
        end
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Advance one cycle, compare every output with the model and tally DUT pulses.
    task automatic step();
        @(negedge clk);
        chk("en_seg",   int'(bus.en_seg),   int'(exp_en_seg));
        chk("en_min",   int'(bus.en_min),   int'(exp_en_min));
        chk("en_hora",  int'(bus.en_hora),  int'(exp_en_hora));
        chk("modo",     int'(bus.modo),     exp_modo);
        chk("parpadeo", int'(bus.parpadeo), int'(exp_par));
        n_seg  += int'(bus.en_seg);
        n_min  += int'(bus.en_min);
        n_hora += int'(bus.en_hora);
    endtask

    task automatic press(input bit pm, input bit pi);
        bus.pulsador_modo = pm;
        bus.pulsador_inc  = pi;
        repeat (8) step();
        bus.pulsador_modo = 1'b0;
        bus.pulsador_inc  = 1'b0;
        repeat (8) step();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_en_seg"},   int'(bus.en_seg),   0);
        chk({name, "_en_min"},   int'(bus.en_min),   0);
        chk({name, "_en_hora"},  int'(bus.en_hora),  0);
        chk({name, "_modo"},     int'(bus.modo),     0);
        chk({name, "_parpadeo"}, int'(bus.parpadeo), 0);
    endtask

    initial begin
        int seg_at[$];
        int s0, mi0, h0, t0, t1, first_seg;
        int par_ref[6];
        int modo_seen[16];
        int par_seen[16];
        bit hit;
        total = 0; bad = 0; n_seg = 0; n_min = 0; n_hora = 0;
        par_ref = '{1, 1, 1, 0, 0, 0};
        rst_n = 1'b0;
        bus.pulsador_modo = 1'b0;
        bus.pulsador_inc  = 1'b0;
        bus.fin_seg = 1'b0;
        bus.fin_min = 1'b0;

        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Free-running seconds after reset release.
        for (int i = 1; i <= 35; i++) begin
            step();
            if (bus.en_seg) seg_at.push_back(i);
        end
        chk("seg_pulse_count", seg_at.size(), 3);
        if (seg_at.size() == 3) begin
            chk("seg_at_0", seg_at[0], 10);
            chk("seg_at_1", seg_at[1], 20);
            chk("seg_at_2", seg_at[2], 30);
        end
        chk("run_no_min", n_min, 0);
        chk("run_no_hora", n_hora, 0);

        // Carries with fin_seg and fin_min high.
        bus.fin_seg = 1'b1;
        bus.fin_min = 1'b1;
        s0 = n_seg; mi0 = n_min; h0 = n_hora;
        repeat (20) step();
        chk("carry_seg", n_seg - s0, 2);
        chk("carry_min", n_min - mi0, 2);
        chk("carry_hora", n_hora - h0, 2);
        bus.fin_seg = 1'b0;
        bus.fin_min = 1'b0;

        // Increment in RUN has no effect.
        mi0 = n_min; h0 = n_hora;
        press(1'b0, 1'b1);
        chk("run_inc_min", n_min - mi0, 0);
        chk("run_inc_hora", n_hora - h0, 0);
        chk("run_inc_modo", int'(bus.modo), 0);

        // Bouncing mode button: 1,0,1 then steady 1.
        bus.pulsador_modo = 1'b1;
        step();
        bus.pulsador_modo = 1'b0;
        step();
        bus.pulsador_modo = 1'b1;
        for (int j = 3; j <= 14; j++) begin
            step();
            modo_seen[j] = int'(bus.modo);
            par_seen[j]  = int'(bus.parpadeo);
        end
        chk("bounce_modo_before", modo_seen[7], 0);
        chk("bounce_modo_after", modo_seen[8], 1);
        for (int j = 0; j < 6; j++) chk("blink_seq", par_seen[8 + j], par_ref[j]);
        bus.pulsador_modo = 1'b0;
        repeat (8) step();
        chk("bounce_single_step", int'(bus.modo), 1);

        // SET_HORA increment, then simultaneous mode + increment.
        s0 = n_seg; mi0 = n_min; h0 = n_hora;
        press(1'b0, 1'b1);
        chk("sethora_inc_hora", n_hora - h0, 1);
        chk("sethora_inc_min", n_min - mi0, 0);
        h0 = n_hora;
        press(1'b1, 1'b1);
        chk("simul_modo", int'(bus.modo), 2);
        chk("simul_no_hora", n_hora - h0, 0);
        chk("sethora_no_seg", n_seg - s0, 0);

        // SET_MIN: three increments.
        s0 = n_seg; mi0 = n_min; h0 = n_hora;
        repeat (3) press(1'b0, 1'b1);
        chk("setmin_min", n_min - mi0, 3);
        chk("setmin_seg", n_seg - s0, 0);
        chk("setmin_hora", n_hora - h0, 0);

        // Back to RUN: first second exactly 10 cycles after the mode change.
        bus.pulsador_modo = 1'b1;
        t0 = -1; t1 = -1;
        for (int j = 1; j <= 30; j++) begin
            step();
            if (j == 8) bus.pulsador_modo = 1'b0;
            if (t0 >= 0 && t1 < 0 && bus.en_seg) t1 = j;
            if (t0 < 0 && bus.modo == 2'b00) t0 = j;
        end
        chk("run_entry_latency", t0, 6);
        chk("run_restart", t1 - t0, 10);

        // Mode press landing on a tick: second still counted, mode still steps.
        bus.pulsador_modo = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) begin
                chk("tick_modo_seg", int'(bus.en_seg), 1);
                chk("tick_modo_modo", int'(bus.modo), 1);
            end
        end
        bus.pulsador_modo = 1'b0;
        repeat (8) step();

        // Enter SET_MIN and reset while blinking high.
        bus.pulsador_modo = 1'b1;
        hit = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (bus.modo == 2'b10) begin
                hit = 1'b1;
                break;
            end
        end
        chk("setmin_entry", int'(hit), 1);
        chk("setmin_entry_blink", int'(bus.parpadeo), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        bus.pulsador_modo = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        s0 = n_seg; mi0 = n_min; h0 = n_hora;
        first_seg = -1;
        for (int j = 1; j <= 15; j++) begin
            step();
            if (first_seg < 0 && bus.en_seg) first_seg = j;
        end
        chk("post_reset_first_seg", first_seg, 10);
        chk("post_reset_seg", n_seg - s0, 1);
        chk("post_reset_min", n_min - mi0, 0);
        chk("post_reset_hora", n_hora - h0, 0);
        chk("post_reset_modo", int'(bus.modo), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
